// File: rtl/pico_conf_pkg.sv
// rtl/pico_conf_pkg.sv - command/response codes and FSM states for pico_conf_loader (honours PICO_CONF_READBACK_EN)
package pico_conf_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_START = 8'h03;
  localparam logic [7:0] CMD_HALT  = 8'h04;

  localparam logic [7:0] RSP_WR_ACK    = 8'hA1;
  localparam logic [7:0] RSP_START_ACK = 8'hA3;
  localparam logic [7:0] RSP_HALT_ACK  = 8'hA4;
  localparam logic [7:0] RSP_LOCKED    = 8'hE1;
  localparam logic [7:0] RSP_ERROR     = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_WR      = 3'd3,
`ifdef PICO_CONF_READBACK_EN
    ST_RD      = 3'd4,
    ST_RD_WAIT = 3'd5,
`endif
    ST_RSP     = 3'd6
  } state_t;

endpackage

// File: rtl/pico_conf_rsp_ser.sv
// rtl/pico_conf_rsp_ser.sv - shifts a 1- or 4-byte response out LSB first on tx_valid/tx_ready
module pico_conf_rsp_ser (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        load_len4,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        done
);

  // Bytes still queued behind the one currently on tx_data.
  logic [23:0] pending;
  logic [1:0]  byte_cnt;

  assign done = tx_valid & tx_ready & (byte_cnt == 2'd0);

  // Present the low byte on load, then step to the next byte on every handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      pending  <= 24'h0;
      byte_cnt <= 2'd0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= load_word[7:0];
      pending  <= load_word[31:8];
      byte_cnt <= load_len4 ? 2'd3 : 2'd0;
    end else if (tx_valid && tx_ready) begin
      if (byte_cnt == 2'd0) begin
        tx_valid <= 1'b0;
      end else begin
        tx_data  <= pending[7:0];
        pending  <= {8'h00, pending[23:8]};
        byte_cnt <= byte_cnt - 2'd1;
      end
    end
  end

endmodule

// File: rtl/pico_conf_loader.sv
// rtl/pico_conf_loader.sv - framed byte-stream initiator for the PicoSoC config port (READ needs PICO_CONF_READBACK_EN)
module pico_conf_loader
  import pico_conf_pkg::*;
#(
  parameter int RD_LATENCY     = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        conf_sel,
  output logic        conf_wren,
  output logic        conf_rden,
  output logic [31:0] conf_addr,
  output logic [31:0] conf_wdata,
  input  logic [31:0] conf_rdata
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        is_write;
  logic [1:0]  byte_cnt;
  logic [31:0] tmo_cnt;

  logic        rx_fire;
  logic        last_byte;
  logic        timed_out;
  logic        rsp_load;
  logic        rsp_len4;
  logic [31:0] rsp_word;
  logic        rsp_done;

`ifdef PICO_CONF_READBACK_EN
  logic        rden_q;
  logic [2:0]  lat_cnt;
  assign conf_rden = rden_q;
`else
  // Readback hardware is absent; the read port and its latency are deliberately unused.
  logic        unused_readback;
  assign conf_rden       = 1'b0;
  assign unused_readback = ^{conf_rdata, 3'(RD_LATENCY)};
`endif

  // Bytes are only taken while a frame is being assembled, never during reset.
  assign rx_ready  = ~reset & ((state == ST_IDLE) | (state == ST_ADDR) | (state == ST_DATA));
  assign rx_fire   = rx_valid & rx_ready;
  assign last_byte = rx_fire & (byte_cnt == 2'd3);
  assign timed_out = ~rx_fire & (tmo_cnt == TMO_LAST);

  // Decide which response (if any) enters the serializer this cycle.
  always_comb begin
    rsp_load = 1'b0;
    rsp_len4 = 1'b0;
    rsp_word = 32'h0;
    case (state)
      ST_IDLE: begin
        if (rx_fire) begin
          case (rx_data)
            CMD_WRITE: ;
`ifdef PICO_CONF_READBACK_EN
            CMD_READ:  ;
`endif
            CMD_START: begin rsp_load = 1'b1; rsp_word = {24'h0, RSP_START_ACK}; end
            CMD_HALT:  begin rsp_load = 1'b1; rsp_word = {24'h0, RSP_HALT_ACK};  end
            default:   begin rsp_load = 1'b1; rsp_word = {24'h0, RSP_ERROR};     end
          endcase
        end
      end
      ST_ADDR: begin
        if (timed_out) begin
          rsp_load = 1'b1;
          rsp_word = {24'h0, RSP_ERROR};
`ifdef PICO_CONF_READBACK_EN
        end else if (last_byte && !is_write && !conf_sel) begin
          rsp_load = 1'b1;
          rsp_word = {24'h0, RSP_LOCKED};
`endif
        end
      end
      ST_DATA: begin
        if (timed_out) begin
          rsp_load = 1'b1;
          rsp_word = {24'h0, RSP_ERROR};
        end else if (last_byte && !conf_sel) begin
          rsp_load = 1'b1;
          rsp_word = {24'h0, RSP_LOCKED};
        end
      end
      ST_WR: begin
        rsp_load = 1'b1;
        rsp_word = {24'h0, RSP_WR_ACK};
      end
`ifdef PICO_CONF_READBACK_EN
      // The serializer's shift register doubles as the readback capture register.
      ST_RD_WAIT: begin
        if (lat_cnt == 3'(RD_LATENCY)) begin
          rsp_load = 1'b1;
          rsp_len4 = 1'b1;
          rsp_word = conf_rdata;
        end
      end
`endif
      default: ;
    endcase
  end

  // Frame decoder: assembles address/data, issues strobes and owns conf_sel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      is_write   <= 1'b0;
      byte_cnt   <= 2'd0;
      tmo_cnt    <= 32'd0;
      conf_sel   <= 1'b1;
      conf_wren  <= 1'b0;
      conf_addr  <= 32'h0;
      conf_wdata <= 32'h0;
`ifdef PICO_CONF_READBACK_EN
      rden_q     <= 1'b0;
      lat_cnt    <= 3'd0;
`endif
    end else begin
      conf_wren <= 1'b0;
`ifdef PICO_CONF_READBACK_EN
      rden_q    <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          byte_cnt <= 2'd0;
          tmo_cnt  <= 32'd0;
          if (rx_fire) begin
            if (rx_data == CMD_WRITE) begin
              is_write <= 1'b1;
              state    <= ST_ADDR;
`ifdef PICO_CONF_READBACK_EN
            end else if (rx_data == CMD_READ) begin
              is_write <= 1'b0;
              state    <= ST_ADDR;
`endif
            end else begin
              // conf_sel flips on the same edge the ack enters the serializer.
              if (rx_data == CMD_START) conf_sel <= 1'b0;
              else if (rx_data == CMD_HALT) conf_sel <= 1'b1;
              state <= ST_RSP;
            end
          end
        end
        ST_ADDR: begin
          if (rx_fire) begin
            conf_addr[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            tmo_cnt  <= 32'd0;
            if (last_byte) begin
              if (is_write) begin
                state <= ST_DATA;
`ifdef PICO_CONF_READBACK_EN
              end else if (conf_sel) begin
                rden_q <= 1'b1;
                state  <= ST_RD;
`endif
              end else begin
                state <= ST_RSP;
              end
            end
          end else if (timed_out) begin
            byte_cnt <= 2'd0;
            state    <= ST_RSP;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        ST_DATA: begin
          if (rx_fire) begin
            conf_wdata[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            tmo_cnt  <= 32'd0;
            if (last_byte) begin
              if (conf_sel) begin
                conf_wren <= 1'b1;
                state     <= ST_WR;
              end else begin
                state <= ST_RSP;
              end
            end
          end else if (timed_out) begin
            byte_cnt <= 2'd0;
            state    <= ST_RSP;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        ST_WR: begin
          state <= ST_RSP;
        end
`ifdef PICO_CONF_READBACK_EN
        ST_RD: begin
          lat_cnt <= 3'd1;
          state   <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (rsp_load) state <= ST_RSP;
          else lat_cnt <= lat_cnt + 3'd1;
        end
`endif
        ST_RSP: begin
          if (rsp_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pico_conf_rsp_ser u_rsp_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (rsp_load),
    .load_word (rsp_word),
    .load_len4 (rsp_len4),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .done      (rsp_done)
  );

endmodule

// File: tb/tb_pico_conf_loader.sv
// tb/tb_pico_conf_loader.sv - randomized scoreboard bench for pico_conf_loader (follows PICO_CONF_READBACK_EN)
module tb_pico_conf_loader;

  localparam int RD_LAT = 2;
  localparam int TMO    = 100;
`ifdef PICO_CONF_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        conf_sel, conf_wren, conf_rden;
  logic [31:0] conf_addr, conf_wdata, conf_rdata;

  always #5 clk = ~clk;

  pico_conf_loader #(.RD_LATENCY(RD_LAT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .conf_sel(conf_sel), .conf_wren(conf_wren), .conf_rden(conf_rden),
    .conf_addr(conf_addr), .conf_wdata(conf_wdata), .conf_rdata(conf_rdata)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [7:0] b; logic sel; } rsp_t;
  rsp_t        exp_q[$];
  logic [63:0] wr_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];
  logic        ref_sel = 1'b1;
  bit          stall_mid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory behind the config port: writes land immediately, reads appear exactly RD_LAT cycles after rden.
  logic [31:0] pipe_d [RD_LAT];
  logic        pipe_v [RD_LAT];
  initial for (int i = 0; i < RD_LAT; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = 32'h0; end
  always @(posedge clk) begin
    if (conf_wren) bus_mem[conf_addr] = conf_wdata;
    pipe_v[0] <= conf_rden;
    pipe_d[0] <= bus_mem.exists(conf_addr) ? bus_mem[conf_addr] : 32'h0;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign conf_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 32'hBAD0_BAD0;

  // Monitor: drives tx_ready, checks held bytes, pops the scoreboard on each handshake and each write strobe.
  int         stall_left = 0;
  bit         held = 1'b0;
  logic [7:0] held_data = 8'h00;
  always @(negedge clk) begin
    rsp_t       e;
    logic [63:0] w;
    if (reset) begin
      held = 1'b0;
      tx_ready = 1'b0;
    end else begin
      if (held) begin
        check("tx_hold_valid", tx_valid, 1);
        check("tx_hold_data", tx_data, held_data);
      end
      if (stall_left > 0) begin
        tx_ready = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 11) == 0) begin
        tx_ready = 1'b0;
        stall_left = 4;
      end else begin
        tx_ready = ($urandom_range(0, 3) != 0);
      end
      held = tx_valid && !tx_ready;
      held_data = tx_data;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("tx_unexpected_byte", tx_data, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", tx_data, e.b);
          check("conf_sel_at_rsp", conf_sel, e.sel);
          if (stall_mid && exp_q.size() == 2) begin
            stall_left = 5;
            stall_mid = 1'b0;
          end
        end
      end
      if (conf_wren) begin
        if (wr_q.size() == 0) begin
          check("wren_unexpected", conf_wren, 0);
        end else begin
          w = wr_q.pop_front();
          check("wren_addr", conf_addr, w[63:32]);
          check("wren_data", conf_wdata, w[31:0]);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data = b;
    while (!rx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rx_accept_in_time", (n < 300), 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while ((exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rsp_drained_in_time", (n < 3000), 1);
  endtask

  task automatic push_rsp(input logic [7:0] b);
    rsp_t e;
    e.b = b;
    e.sel = ref_sel;
    exp_q.push_back(e);
  endtask

  // Reference model: one whole frame in, the expected bytes/strobes out.
  task automatic do_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
    logic [7:0]  bytes[$];
    logic [31:0] v;
    bit          is_wr = (cmd == 8'h01);
    bit          is_rd = (cmd == 8'h02) && READBACK;
    bytes.push_back(cmd);
    if (is_wr || is_rd) for (int i = 0; i < 4; i++) bytes.push_back(addr[8*i +: 8]);
    if (is_wr) for (int i = 0; i < 4; i++) bytes.push_back(data[8*i +: 8]);
    if (is_wr) begin
      if (ref_sel) begin
        ref_mem[addr] = data;
        wr_q.push_back({addr, data});
        push_rsp(8'hA1);
      end else push_rsp(8'hE1);
    end else if (is_rd) begin
      if (ref_sel) begin
        v = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
        for (int i = 0; i < 4; i++) push_rsp(v[8*i +: 8]);
      end else push_rsp(8'hE1);
    end else if (cmd == 8'h03) begin
      ref_sel = 1'b0;
      push_rsp(8'hA3);
    end else if (cmd == 8'h04) begin
      ref_sel = 1'b1;
      push_rsp(8'hA4);
    end else push_rsp(8'hEE);
    foreach (bytes[i]) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(bytes[i]);
    end
    if (is_wr && ref_sel) check("wren_latency", conf_wren, 1);
    if (is_rd && ref_sel) begin
      check("rden_latency", conf_rden, 1);
      check("rden_addr", conf_addr, addr);
    end
    wait_rsp();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_conf_sel"}, conf_sel, 1);
    check({tag, "_conf_wren"}, conf_wren, 0);
    check({tag, "_conf_rden"}, conf_rden, 0);
    check({tag, "_conf_addr"}, conf_addr, 0);
    check({tag, "_conf_wdata"}, conf_wdata, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_rx_ready"}, rx_ready, 0);
  endtask

  // Abandon a WRITE inside its data bytes by asserting reset between edges.
  task automatic reset_mid_write(input logic [31:0] addr);
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    send_byte(8'h44);
    send_byte(8'h55);
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    ref_sel = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_rx_ready", rx_ready, 1);
    check("post_reset_conf_sel", conf_sel, 1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmd;
    int         r;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("in_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_rx_ready", rx_ready, 1);
    check("idle_tx_valid", tx_valid, 0);
    check("idle_conf_sel", conf_sel, 1);
    check("idle_conf_wren", conf_wren, 0);
    check("idle_conf_rden", conf_rden, 0);
    @(negedge clk);

    do_frame(8'h01, 32'h0000_0010, 32'hDEAD_BEEF);
    stall_mid = READBACK;
    do_frame(8'h02, 32'h0000_0010, 32'h0);
    stall_mid = 1'b0;

    do_frame(8'h03, 32'h0, 32'h0);
    check("start_conf_sel", conf_sel, 0);
    do_frame(8'h01, 32'h0000_0014, 32'h1234_5678);
    do_frame(8'h04, 32'h0, 32'h0);
    check("halt_conf_sel", conf_sel, 1);

    // Timeout: two bytes then silence; the frame must be dropped with 0xEE.
    push_rsp(8'hEE);
    send_byte(8'h01);
    send_byte(8'h20);
    wait_rsp();
    repeat (2) @(negedge clk);
    check("timeout_back_idle", rx_ready, 1);
    do_frame(8'h7F, 32'h0, 32'h0);

    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) cmd = 8'h01;
      else if (r < 7) cmd = 8'h02;
      else if (r == 7) cmd = ($urandom_range(0, 2) == 0) ? 8'h03 : 8'h04;
      else if (r == 8) cmd = 8'h04;
      else begin
        cmd = 8'($urandom);
        while (cmd >= 8'h01 && cmd <= 8'h04) cmd = 8'($urandom);
      end
      do_frame(cmd, 32'h100 + 32'($urandom_range(0, 7)), $urandom);
    end

    do_frame(8'h03, 32'h0, 32'h0);
    reset_mid_write(32'h0000_0030);
    reset_mid_write(32'h0000_0034);
    do_frame(8'h01, 32'h0000_0034, 32'hCAFE_F00D);
    do_frame(8'h02, 32'h0000_0034, 32'h0);

    repeat (5) @(negedge clk);
    check("wren_queue_empty", wr_q.size(), 0);
    check("rsp_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
